test_pattern_gen: RTL and testbench
===================================

TEST_PATTERN_GEN -- requirements
Module: test_pattern_gen

Interface
REQ-001 Parameter WIDTH, default 640: active pixels per line, range 2..4096.
REQ-002 Parameter HEIGHT, default 480: active lines per frame, range 2..4096.
REQ-003 Parameter H_BLANK, default 16: lval-low cycles between lines, and before the first and after the last line inside fval, range 2..255.
REQ-004 Parameter V_BLANK, default 32: minimum fval-low cycles between frames, range 2..65535.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 en  input  1  frame request; sampled only in IDLE and at end of vertical blank.
REQ-008 sel  input  3  pattern select; latched at frame start.
REQ-009 fval  output  1  frame valid.
REQ-010 lval  output  1  line valid.
REQ-011 dval  output  1  pixel valid; equals lval in this block.
REQ-012 pix_data  output  8  pixel value; 0 whenever dval=0.
REQ-013 frame_done  output  1  one-cycle pulse on the cycle fval falls.

Function
REQ-014 All outputs SHALL be registered; no combinational input-to-output path.
REQ-015 States SHALL be IDLE, F_PRE, LINE, H_GAP, V_GAP.
REQ-016 IDLE: fval=lval=0; if en=1 at a rising edge, next cycle enter F_PRE with fval=1 and sel latched into sel_q.
REQ-017 F_PRE: fval=1, lval=0 for exactly H_BLANK cycles, then LINE.
REQ-018 LINE: lval=dval=1 for exactly WIDTH cycles; x counts 0..WIDTH-1; then H_GAP.
REQ-019 H_GAP: fval=1, lval=0 for H_BLANK cycles; if y<HEIGHT-1, increment y, clear x, return to LINE; else go to V_GAP.
REQ-020 Entry to V_GAP SHALL drop fval and pulse frame_done in the same cycle.
REQ-021 V_GAP: fval=0 for V_BLANK cycles; on the last cycle, en=1 SHALL start the next frame (F_PRE, new sel_q latched), else go to IDLE.
REQ-022 Frame period with continuous en SHALL be (WIDTH+H_BLANK)*HEIGHT + H_BLANK + V_BLANK cycles.
REQ-023 en deasserted mid-frame SHALL NOT truncate the frame; it completes and then returns to IDLE.
REQ-024 sel changes mid-frame SHALL have no effect until the next frame start.
REQ-025 x and y SHALL be 12 bits; pix_data derived from x, y and sel_q per REQ-026.
REQ-026 Patterns: 000 -> 0x00; 001 -> 0xFF; 010 -> x[7:0] (horizontal ramp, wraps every 256); 011 -> 0xFF if x[5]^y[5] else 0x00 (32x32 checkers); 100 -> y[7:0]; 101 -> (x+y)[7:0]; 110 -> m[7:0] where m = min(x, y, WIDTH-1-x, HEIGHT-1-y) (concentric squares); 111 -> 0x80.

Reset
REQ-027 rst=1 SHALL force IDLE immediately, with fval=lval=dval=frame_done=0, pix_data=0, x=y=0, sel_q=000.
REQ-028 rst asserted mid-frame SHALL abort the frame with no frame_done pulse; after release, generation restarts only from IDLE via en.

Structure
REQ-029 A shared package frame_gen_pkg SHALL hold the sel code constants (PAT_BLACK .. PAT_CONST) and the state encoding, for use by this block and its benches.
REQ-030 The pixel function SHALL be a sub-module, pattern_pixel: inputs x, y, sel_q; output pix value; combinational; the final register is in the top.

Verification (WIDTH=8, HEIGHT=4, H_BLANK=2, V_BLANK=3)
REQ-031 en held 1, sel=010 -> fval high 42 cycles, 4 lval bursts of 8 each, pix_data 0..7 per line, frame_done pulses once per 45 cycles.
REQ-032 sel=011 with WIDTH=64, HEIGHT=64 -> line 0 pixels 0..31 = 0x00 and 32..63 = 0xFF; line 32 inverted.
REQ-033 sel=110 -> line 0 all 0x00; line 1 = 00,01,01,01,01,01,01,00.
REQ-034 en pulsed 1 cycle in IDLE -> exactly one frame, then IDLE; sel changed 000->001 on line 2 -> all pix_data 0x00 for that frame.
REQ-035 rst asserted on line 2, pixel 3 -> all outputs 0 in the same cycle, no frame_done; with en=1 after release, the next frame starts with line 0, pixel 0.

Source files
------------

// File: rtl/frame_gen_pkg.sv
// Shared definitions for the test pattern generator and its benches:
// pattern select codes, FSM state encoding and a small min helper.
package frame_gen_pkg;

    localparam int COORD_W = 12;

    // Pattern select codes carried on sel / sel_q
    localparam logic [2:0] PAT_BLACK   = 3'b000;
    localparam logic [2:0] PAT_WHITE   = 3'b001;
    localparam logic [2:0] PAT_HRAMP   = 3'b010;
    localparam logic [2:0] PAT_CHECKER = 3'b011;
    localparam logic [2:0] PAT_VRAMP   = 3'b100;
    localparam logic [2:0] PAT_DIAG    = 3'b101;
    localparam logic [2:0] PAT_SQUARES = 3'b110;
    localparam logic [2:0] PAT_CONST   = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        F_PRE,
        LINE,
        H_GAP,
        V_GAP
    } state_e;

    function automatic logic [COORD_W-1:0] min2(input logic [COORD_W-1:0] a,
                                                input logic [COORD_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/test_pattern_gen_if.sv
// Video output bundle of the test pattern generator plus its frame request
// controls. master is the generator side, slave the consumer/controller side.
interface test_pattern_gen_if;
    logic       en;
    logic [2:0] sel;
    logic       fval;
    logic       lval;
    logic       dval;
    logic [7:0] pix_data;
    logic       frame_done;

    modport master (
        input  en, sel,
        output fval, lval, dval, pix_data, frame_done
    );

    modport slave (
        output en, sel,
        input  fval, lval, dval, pix_data, frame_done
    );
endinterface

// File: rtl/pattern_pixel.sv
// Combinational pixel function: maps coordinates and the latched pattern
// select to an 8-bit pixel value. The output register lives in the top.
module pattern_pixel
    import frame_gen_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [2:0]         sel_q,
    output logic [7:0]         pix
);

    logic [COORD_W-1:0] dist_right;
    logic [COORD_W-1:0] dist_bottom;
    logic [COORD_W-1:0] ring;

    // Distance to the nearest frame edge gives the concentric squares
    assign dist_right  = COORD_W'(WIDTH - 1) - x;
    assign dist_bottom = COORD_W'(HEIGHT - 1) - y;
    assign ring        = min2(min2(x, y), min2(dist_right, dist_bottom));

    // Pattern selection
    always_comb begin
        pix = 8'h00;
        case (sel_q)
            PAT_BLACK:   pix = 8'h00;
            PAT_WHITE:   pix = 8'hFF;
            PAT_HRAMP:   pix = x[7:0];
            PAT_CHECKER: pix = (x[5] ^ y[5]) ? 8'hFF : 8'h00;
            PAT_VRAMP:   pix = y[7:0];
            PAT_DIAG:    pix = 8'(x + y);
            PAT_SQUARES: pix = 8'(ring);
            PAT_CONST:   pix = 8'h80;
            default:     pix = 8'h00;
        endcase
    end

endmodule

// File: rtl/test_pattern_gen.sv
// Test pattern generator: produces fval/lval/dval framing with a selectable
// pixel pattern. All outputs come straight from registers.
module test_pattern_gen
    import frame_gen_pkg::*;
#(
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int H_BLANK = 16,
    parameter int V_BLANK = 32
) (
    input  logic              clk,
    input  logic              rst,
    test_pattern_gen_if.master vid
);

    localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_LAST  = COORD_W'(HEIGHT - 1);
    localparam logic [15:0]        HB_LAST = 16'(H_BLANK - 1);
    localparam logic [15:0]        VB_LAST = 16'(V_BLANK - 1);

    state_e             state_reg;
    logic [15:0]        cnt_reg;
    logic [COORD_W-1:0] x_reg;
    logic [COORD_W-1:0] y_reg;
    logic [2:0]         sel_q;
    logic               fval_reg;
    logic               lval_reg;
    logic               frame_done_reg;
    logic [7:0]         pix_reg;

    logic [COORD_W-1:0] x_next;
    logic [COORD_W-1:0] y_next;
    logic [7:0]         pix_next;

    // Coordinates of the pixel that will be on the bus next cycle, so the
    // pixel register lines up with lval without an extra pipeline stage
    always_comb begin
        x_next = '0;
        y_next = y_reg;
        case (state_reg)
            LINE:    x_next = x_reg + 12'd1;
            H_GAP:   y_next = y_reg + 12'd1;
            default: ;
        endcase
    end

    pattern_pixel #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_pixel (
        .x     (x_next),
        .y     (y_next),
        .sel_q (sel_q),
        .pix   (pix_next)
    );

    // Frame FSM with registered framing and pixel outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            x_reg          <= '0;
            y_reg          <= '0;
            sel_q          <= PAT_BLACK;
            fval_reg       <= 1'b0;
            lval_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
            pix_reg        <= 8'h00;
        end else begin
            frame_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (vid.en) begin
                        state_reg <= F_PRE;
                        fval_reg  <= 1'b1;
                        sel_q     <= vid.sel;
                        cnt_reg   <= '0;
                        x_reg     <= '0;
                        y_reg     <= '0;
                    end
                end
                F_PRE: begin
                    if (cnt_reg == HB_LAST) begin
                        state_reg <= LINE;
                        lval_reg  <= 1'b1;
                        pix_reg   <= pix_next;
                        x_reg     <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                LINE: begin
                    if (x_reg == X_LAST) begin
                        state_reg <= H_GAP;
                        lval_reg  <= 1'b0;
                        pix_reg   <= 8'h00;
                        cnt_reg   <= '0;
                    end else begin
                        x_reg   <= x_next;
                        pix_reg <= pix_next;
                    end
                end
                H_GAP: begin
                    if (cnt_reg == HB_LAST) begin
                        if (y_reg == Y_LAST) begin
                            state_reg      <= V_GAP;
                            fval_reg       <= 1'b0;
                            frame_done_reg <= 1'b1;
                            cnt_reg        <= '0;
                        end else begin
                            state_reg <= LINE;
                            lval_reg  <= 1'b1;
                            pix_reg   <= pix_next;
                            y_reg     <= y_next;
                            x_reg     <= '0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                V_GAP: begin
                    if (cnt_reg == VB_LAST) begin
                        if (vid.en) begin
                            state_reg <= F_PRE;
                            fval_reg  <= 1'b1;
                            sel_q     <= vid.sel;
                            cnt_reg   <= '0;
                            x_reg     <= '0;
                            y_reg     <= '0;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign vid.fval       = fval_reg;
    assign vid.lval       = lval_reg;
    assign vid.dval       = lval_reg;
    assign vid.pix_data   = pix_reg;
    assign vid.frame_done = frame_done_reg;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Bench for test_pattern_gen: a small 8x4 instance checked every cycle against
// a frame-timing model, plus a 64x64 instance for the checkerboard pattern.
module tb_test_pattern_gen;

    localparam int W   = 8;
    localparam int H   = 4;
    localparam int HB  = 2;
    localparam int VB  = 3;
    localparam int FH  = HB + H * (W + HB);   // fval-high cycles per frame
    localparam int P   = FH + VB;             // frame period with en held
    localparam int W2  = 64;
    localparam int H2  = 64;

    logic clk = 1'b0;
    logic rst;

    test_pattern_gen_if vif ();
    test_pattern_gen_if vif2 ();

    test_pattern_gen #(.WIDTH(W), .HEIGHT(H), .H_BLANK(HB), .V_BLANK(VB)) dut (
        .clk (clk),
        .rst (rst),
        .vid (vif)
    );

    test_pattern_gen #(.WIDTH(W2), .HEIGHT(H2), .H_BLANK(HB), .V_BLANK(VB)) dut2 (
        .clk (clk),
        .rst (rst),
        .vid (vif2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state: whether a frame is in progress, the cycle index
    // within the frame period, and the pattern latched for it
    bit busy = 1'b0;
    int t    = 0;
    int msel = 0;

    function automatic int ref_pix(int x, int y, int s, int w, int h);
        int r;
        int m;
        r = 0;
        case (s)
            0: r = 0;
            1: r = 255;
            2: r = x % 256;
            3: r = (((x / 32) % 2) != ((y / 32) % 2)) ? 255 : 0;
            4: r = y % 256;
            5: r = (x + y) % 256;
            6: begin
                m = x;
                if (y < m) m = y;
                if (w - 1 - x < m) m = w - 1 - x;
                if (h - 1 - y < m) m = h - 1 - y;
                r = m % 256;
            end
            default: r = 128;
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Compare the small DUT's outputs against the model for the current cycle
    task automatic check_main();
        int ef, el, ep, ed, u, ln, pos;
        ef = 0; el = 0; ep = 0; ed = 0;
        if (busy) begin
            ef = (t < FH) ? 1 : 0;
            ed = (t == FH) ? 1 : 0;
            if (t >= HB && t < FH) begin
                u   = t - HB;
                ln  = u / (W + HB);
                pos = u % (W + HB);
                if (pos < W) begin
                    el = 1;
                    ep = ref_pix(pos, ln, msel, W, H);
                end
            end
        end
        check("fval",       32'(vif.fval),       32'(ef));
        check("lval",       32'(vif.lval),       32'(el));
        check("dval",       32'(vif.dval),       32'(el));
        check("pix_data",   32'(vif.pix_data),   32'(ep));
        check("frame_done", 32'(vif.frame_done), 32'(ed));
    endtask

    // Advance one clock, update the model from the inputs seen at the edge,
    // then compare just after the edge
    task automatic step();
        @(posedge clk);
        cyc++;
        if (rst) begin
            busy = 1'b0;
        end else if (!busy) begin
            if (vif.en) begin
                busy = 1'b1;
                t    = 0;
                msel = int'(vif.sel);
            end
        end else if (t == P - 1) begin
            if (vif.en) begin
                t    = 0;
                msel = int'(vif.sel);
            end else begin
                busy = 1'b0;
            end
        end else begin
            t++;
        end
        #1;
        check_main();
    endtask

    initial begin
        int last_fd;
        int n_fd;
        int xx;

        rst      = 1'b1;
        vif.en   = 1'b0;
        vif.sel  = 3'b000;
        vif2.en  = 1'b0;
        vif2.sel = 3'b000;

        // Reset state
        repeat (3) step();
        rst = 1'b0;
        repeat (2) step();

        // Continuous en with horizontal ramp; measure frame_done spacing
        vif.en  = 1'b1;
        vif.sel = 3'b010;
        last_fd = -1;
        n_fd    = 0;
        for (int i = 0; i < 2 * P + 1; i++) begin
            step();
            if (vif.frame_done === 1'b1) begin
                if (last_fd >= 0) check("frame_period", 32'(cyc - last_fd), 32'(P));
                last_fd = cyc;
                n_fd++;
            end
        end
        check("frame_done_count", 32'(n_fd), 32'd2);

        // en dropped mid-frame: frame completes, then idle
        vif.en = 1'b0;
        repeat (P + 5) step();

        // Concentric squares, single frame
        vif.sel = 3'b110;
        vif.en  = 1'b1;
        step();
        vif.en = 1'b0;
        repeat (P + 3) step();

        // One-cycle en pulse with black, sel switched to white on line 2
        vif.sel = 3'b000;
        vif.en  = 1'b1;
        step();
        vif.en = 1'b0;
        repeat (HB + 2 * (W + HB)) step();
        vif.sel = 3'b001;
        repeat (P) step();

        // Every pattern once, with sel scrambled after the frame starts
        for (int s = 0; s < 8; s++) begin
            vif.sel = 3'(s);
            vif.en  = 1'b1;
            step();
            vif.en  = 1'b0;
            vif.sel = 3'($urandom_range(0, 7));
            repeat (P + 2) step();
        end

        // Reset on line 2, pixel 3: outputs drop at once, no frame_done
        vif.sel = 3'b101;
        vif.en  = 1'b1;
        step();
        vif.en = 1'b0;
        repeat (HB + 2 * (W + HB) + 3) step();
        check("pre_rst_lval", 32'(vif.lval), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        busy = 1'b0;
        check("rst_fval",       32'(vif.fval),       32'd0);
        check("rst_lval",       32'(vif.lval),       32'd0);
        check("rst_dval",       32'(vif.dval),       32'd0);
        check("rst_pix",        32'(vif.pix_data),   32'd0);
        check("rst_frame_done", 32'(vif.frame_done), 32'd0);
        vif.en  = 1'b1;
        vif.sel = 3'b010;
        repeat (2) step();
        rst = 1'b0;
        repeat (P) step();
        vif.en = 1'b0;
        repeat (P + 2) step();

        // Random en / sel traffic
        repeat (600) begin
            vif.en  = ($urandom_range(0, 7) == 0);
            vif.sel = 3'($urandom_range(0, 7));
            step();
        end
        vif.en = 1'b0;
        repeat (P + 2) step();

        // 64x64 checkerboard: line 0 and line 32 at their exact times
        vif2.sel = 3'b011;
        vif2.en  = 1'b1;
        step();
        vif2.en  = 1'b0;
        vif2.sel = 3'b000;
        for (int k = 1; k < HB + 32 * (W2 + HB) + W2; k++) begin
            step();
            if (k >= HB && k < HB + W2) begin
                xx = k - HB;
                check("chk_l0_lval", 32'(vif2.lval), 32'd1);
                check("chk_l0_pix", 32'(vif2.pix_data), (xx < 32) ? 32'h00 : 32'hFF);
            end
            if (k >= HB + 32 * (W2 + HB)) begin
                xx = k - (HB + 32 * (W2 + HB));
                check("chk_l32_lval", 32'(vif2.lval), 32'd1);
                check("chk_l32_pix", 32'(vif2.pix_data), (xx < 32) ? 32'hFF : 32'h00);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
